// File: rtl/cdce_mon_pkg.sv
// Shared types and constants for the CDCE62005 per-frame monitor.
package cdce_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RDCMD = 2'd2,
        ST_RSVD  = 2'd3
    } mon_state_e;

    localparam logic [3:0] CMD_READ   = 4'he;
    localparam logic [3:0] REG_STATUS = 4'h8;
    localparam int         NUM_SHADOW = 8;
    localparam int         SHADOW_W   = 28;

    // Registers 0..7 are the only ones mirrored in the write shadow.
    function automatic logic is_shadow_addr(input logic [3:0] a);
        return ~a[3];
    endfunction

endpackage

// File: rtl/cdce_shadow_regs.sv
// Write shadow of CDCE registers 0..7 with a combinational readback compare.
module cdce_shadow_regs
    import cdce_mon_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                we_i,
    input  logic [2:0]          waddr_i,
    input  logic [SHADOW_W-1:0] wdata_i,
    input  logic [3:0]          caddr_i,
    input  logic [SHADOW_W-1:0] cdata_i,
    output logic                cvalid_o,
    output logic                cmismatch_o
);

    logic [NUM_SHADOW-1:0][SHADOW_W-1:0] shadow_q;
    logic [NUM_SHADOW-1:0]               wr_valid_q;

    for (genvar g = 0; g < NUM_SHADOW; g++) begin : g_ent
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                shadow_q[g]   <= '0;
                wr_valid_q[g] <= 1'b0;
            end else if (we_i && (waddr_i == 3'(g))) begin
                shadow_q[g]   <= wdata_i;
                wr_valid_q[g] <= 1'b1;
            end
        end
    end

    // Unwritten entries never report a mismatch.
    always_comb begin
        cvalid_o    = is_shadow_addr(caddr_i) && wr_valid_q[caddr_i[2:0]];
        cmismatch_o = cvalid_o && (shadow_q[caddr_i[2:0]] != cdata_i);
    end

endmodule

// File: rtl/cdce_frame_monitor.sv
// Per-frame monitor clocked by CS rising edge: shadows writes, verifies readbacks, tracks PLL lock.
module cdce_frame_monitor
    import cdce_mon_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int LOCK_BIT = 12
) (
    input  logic             CLOCK3_SSPCS_o,
    input  logic             FPGA_rst,
    input  logic [31:0]      frame_word,
    input  logic             frame_is_read,
    input  logic [31:0]      Read_data,
    input  logic             clr,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [31:0]      rb_data,
    output logic [3:0]       rb_addr,
    output logic             rb_toggle,
    output logic             verify_err,
    output logic [3:0]       err_addr,
    output logic             proto_err,
    output logic             lock_now,
    output logic             lock_seen,
    output logic             lock_lost,
    output logic [1:0]       state
);

    mon_state_e       state_q, state_d, cur_st;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, cnt_base;
    logic [31:0]      rb_data_q, rb_data_d;
    logic [3:0]       rb_addr_q, rb_addr_d, err_addr_q, err_addr_d, pend_q, pend_d;
    logic             rb_toggle_q, rb_toggle_d, verify_q, verify_d, proto_q, proto_d;
    logic             lock_now_q, lock_now_d, lock_seen_q, lock_seen_d, lock_lost_q, lock_lost_d;
    logic             verify_base, lock_seen_base;
    logic             sh_we, sh_cvalid, sh_mismatch;
    logic [3:0]       a;

    assign a = frame_word[3:0];

    cdce_shadow_regs u_shadow (
        .clk_i       (CLOCK3_SSPCS_o),
        .rst_ni      (FPGA_rst),
        .we_i        (sh_we),
        .waddr_i     (a[2:0]),
        .wdata_i     (frame_word[31:4]),
        .caddr_i     (pend_q),
        .cdata_i     (Read_data[31:4]),
        .cvalid_o    (sh_cvalid),
        .cmismatch_o (sh_mismatch)
    );

    always_comb begin
        cur_st         = (state_q == ST_RSVD) ? ST_IDLE : state_q;
        state_d        = cur_st;
        // clr wipes the stickies first; this frame's events then land on top.
        cnt_base       = clr ? '0 : frame_cnt_q;
        frame_cnt_d    = (&cnt_base) ? cnt_base : cnt_base + 1'b1;
        verify_base    = clr ? 1'b0 : verify_q;
        lock_seen_base = clr ? 1'b0 : lock_seen_q;
        verify_d       = verify_base;
        err_addr_d     = clr ? 4'h0 : err_addr_q;
        proto_d        = clr ? 1'b0 : proto_q;
        lock_seen_d    = lock_seen_base;
        lock_lost_d    = clr ? 1'b0 : lock_lost_q;
        lock_now_d     = lock_now_q;
        rb_data_d      = rb_data_q;
        rb_addr_d      = rb_addr_q;
        rb_toggle_d    = rb_toggle_q;
        pend_d         = pend_q;
        sh_we          = 1'b0;

        if (!frame_is_read) begin
            sh_we = is_shadow_addr(a);
            if (a == CMD_READ) pend_d = frame_word[7:4];
            if (cur_st == ST_RDCMD) proto_d = 1'b1;
            if (cur_st == ST_IDLE) state_d = ST_WRITE;
            else                   state_d = (a == CMD_READ) ? ST_RDCMD : ST_WRITE;
        end else begin
            rb_data_d   = Read_data;
            rb_toggle_d = ~rb_toggle_q;
            if (cur_st == ST_RDCMD) begin
                state_d   = ST_WRITE;
                rb_addr_d = pend_q;
                if (sh_cvalid && sh_mismatch) begin
                    verify_d = 1'b1;
                    if (!verify_base) err_addr_d = pend_q;
                end
                if (pend_q == REG_STATUS) begin
                    lock_now_d = Read_data[LOCK_BIT];
                    if (Read_data[LOCK_BIT])    lock_seen_d = 1'b1;
                    else if (lock_seen_base)    lock_lost_d = 1'b1;
                end
            end else begin
                proto_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK3_SSPCS_o or negedge FPGA_rst) begin
        if (!FPGA_rst) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
            rb_data_q   <= '0;
            rb_addr_q   <= '0;
            rb_toggle_q <= 1'b0;
            verify_q    <= 1'b0;
            err_addr_q  <= '0;
            proto_q     <= 1'b0;
            lock_now_q  <= 1'b0;
            lock_seen_q <= 1'b0;
            lock_lost_q <= 1'b0;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            rb_data_q   <= rb_data_d;
            rb_addr_q   <= rb_addr_d;
            rb_toggle_q <= rb_toggle_d;
            verify_q    <= verify_d;
            err_addr_q  <= err_addr_d;
            proto_q     <= proto_d;
            lock_now_q  <= lock_now_d;
            lock_seen_q <= lock_seen_d;
            lock_lost_q <= lock_lost_d;
            pend_q      <= pend_d;
        end
    end

    assign state      = state_q;
    assign frame_cnt  = frame_cnt_q;
    assign rb_data    = rb_data_q;
    assign rb_addr    = rb_addr_q;
    assign rb_toggle  = rb_toggle_q;
    assign verify_err = verify_q;
    assign err_addr   = err_addr_q;
    assign proto_err  = proto_q;
    assign lock_now   = lock_now_q;
    assign lock_seen  = lock_seen_q;
    assign lock_lost  = lock_lost_q;

endmodule

// File: tb/tb_cdce_frame_monitor.sv
// Directed bench for cdce_frame_monitor: one CS edge per frame, checks sampled 1 ns after the edge.
module tb_cdce_frame_monitor;

    logic        CLOCK3_SSPCS_o = 1'b0;
    logic        FPGA_rst = 1'b0;
    logic [31:0] frame_word = '0;
    logic        frame_is_read = 1'b0;
    logic [31:0] Read_data = '0;
    logic        clr = 1'b0;
    logic [15:0] frame_cnt;
    logic [31:0] rb_data;
    logic [3:0]  rb_addr, err_addr;
    logic        rb_toggle, verify_err, proto_err, lock_now, lock_seen, lock_lost;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    cdce_frame_monitor #(.CNT_W(16), .LOCK_BIT(12)) dut (
        .CLOCK3_SSPCS_o (CLOCK3_SSPCS_o),
        .FPGA_rst       (FPGA_rst),
        .frame_word     (frame_word),
        .frame_is_read  (frame_is_read),
        .Read_data      (Read_data),
        .clr            (clr),
        .frame_cnt      (frame_cnt),
        .rb_data        (rb_data),
        .rb_addr        (rb_addr),
        .rb_toggle      (rb_toggle),
        .verify_err     (verify_err),
        .err_addr       (err_addr),
        .proto_err      (proto_err),
        .lock_now       (lock_now),
        .lock_seen      (lock_seen),
        .lock_lost      (lock_lost),
        .state          (state)
    );

    always #10 CLOCK3_SSPCS_o = ~CLOCK3_SSPCS_o;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] w, input logic rd, input logic [31:0] d, input logic c);
        frame_word    = w;
        frame_is_read = rd;
        Read_data     = d;
        clr           = c;
    endtask

    task automatic frame(input logic [31:0] w, input logic rd, input logic [31:0] d, input logic c);
        @(negedge CLOCK3_SSPCS_o);
        drive(w, rd, d, c);
        @(posedge CLOCK3_SSPCS_o);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".cnt"}, 32'(frame_cnt), 0);
        chk({tag, ".rb_data"}, rb_data, 0);
        chk({tag, ".rb_addr"}, 32'(rb_addr), 0);
        chk({tag, ".tog"}, 32'(rb_toggle), 0);
        chk({tag, ".verr"}, 32'(verify_err), 0);
        chk({tag, ".eaddr"}, 32'(err_addr), 0);
        chk({tag, ".perr"}, 32'(proto_err), 0);
        chk({tag, ".locks"}, {29'd0, lock_now, lock_seen, lock_lost}, 0);
        chk({tag, ".state"}, 32'(state), 0);
    endtask

    initial begin
        repeat (3) @(posedge CLOCK3_SSPCS_o);
        #1 chk_all_zero("reset");

        // Release reset and deliver the first write frame on the same edge.
        @(negedge CLOCK3_SSPCS_o);
        FPGA_rst = 1'b1;
        drive(32'he9400020, 1'b0, 32'h0, 1'b0);
        @(posedge CLOCK3_SSPCS_o);
        #1;
        chk("w1.cnt", 32'(frame_cnt), 1);
        chk("w1.state", 32'(state), 1);

        frame(32'h0000000e, 1'b0, 32'h0, 1'b0);
        chk("rc0.state", 32'(state), 2);
        frame(32'h0, 1'b1, 32'he9400020, 1'b0);
        chk("rb0.verr", 32'(verify_err), 0);
        chk("rb0.addr", 32'(rb_addr), 0);
        chk("rb0.tog", 32'(rb_toggle), 1);
        chk("rb0.cnt", 32'(frame_cnt), 3);
        chk("rb0.state", 32'(state), 1);
        chk("rb0.data", rb_data, 32'he9400020);

        // Mismatch at address 0.
        frame(32'he9400020, 1'b0, 32'h0, 1'b0);
        frame(32'h0000000e, 1'b0, 32'h0, 1'b0);
        frame(32'h0, 1'b1, 32'he9400030, 1'b0);
        chk("mm0.verr", 32'(verify_err), 1);
        chk("mm0.eaddr", 32'(err_addr), 0);
        chk("mm0.tog", 32'(rb_toggle), 0);
        chk("mm0.cnt", 32'(frame_cnt), 6);

        // Later mismatch at address 1 keeps first err_addr.
        frame(32'he9800301, 1'b0, 32'h0, 1'b0);
        frame(32'h0000001e, 1'b0, 32'h0, 1'b0);
        frame(32'h0, 1'b1, 32'he9800310, 1'b0);
        chk("mm1.verr", 32'(verify_err), 1);
        chk("mm1.eaddr", 32'(err_addr), 0);
        chk("mm1.addr", 32'(rb_addr), 1);

        // Lock tracking.
        frame(32'h0000008e, 1'b0, 32'h0, 1'b0);
        frame(32'h0, 1'b1, 32'h00001000, 1'b0);
        chk("lk1.now", 32'(lock_now), 1);
        chk("lk1.seen", 32'(lock_seen), 1);
        chk("lk1.lost", 32'(lock_lost), 0);
        chk("lk1.addr", 32'(rb_addr), 8);
        frame(32'h0000008e, 1'b0, 32'h0, 1'b0);
        frame(32'h0, 1'b1, 32'h00000000, 1'b0);
        chk("lk0.now", 32'(lock_now), 0);
        chk("lk0.lost", 32'(lock_lost), 1);
        chk("lk0.cnt", 32'(frame_cnt), 13);

        // Write after read command, with clr: proto_err set wins, stickies cleared.
        frame(32'h0000001e, 1'b0, 32'h0, 1'b0);
        chk("pe.state", 32'(state), 2);
        frame(32'he9800411, 1'b0, 32'h0, 1'b1);
        chk("pe.perr", 32'(proto_err), 1);
        chk("pe.verr", 32'(verify_err), 0);
        chk("pe.cnt", 32'(frame_cnt), 1);
        chk("pe.seen", 32'(lock_seen), 0);
        chk("pe.lost", 32'(lock_lost), 0);
        chk("pe.state2", 32'(state), 1);
        frame(32'h0, 1'b0, 32'h0, 1'b0); // address 0 write of zero to park state
        chk("pe.state3", 32'(state), 1);
        frame(32'h0000001e, 1'b0, 32'h0, 1'b0);
        frame(32'h0, 1'b1, 32'he9800410, 1'b0);
        chk("sh1.verr", 32'(verify_err), 0);
        chk("sh1.data", rb_data, 32'he9800410);

        // Readback of never-written address 3.
        frame(32'h0000003e, 1'b0, 32'h0, 1'b0);
        frame(32'h0, 1'b1, 32'h12345678, 1'b0);
        chk("uw3.verr", 32'(verify_err), 0);
        chk("uw3.addr", 32'(rb_addr), 3);

        // Mismatch on addr 0 (shadow now zero), then clr with mismatch on addr 1.
        frame(32'h0000000e, 1'b0, 32'h0, 1'b0);
        frame(32'h0, 1'b1, 32'hfffffff0, 1'b0);
        chk("m0.verr", 32'(verify_err), 1);
        chk("m0.eaddr", 32'(err_addr), 0);
        frame(32'h0000001e, 1'b0, 32'h0, 1'b0);
        frame(32'h0, 1'b1, 32'h00000000, 1'b1);
        chk("clr.verr", 32'(verify_err), 1);
        chk("clr.eaddr", 32'(err_addr), 1);
        chk("clr.cnt", 32'(frame_cnt), 1);
        chk("clr.perr", 32'(proto_err), 0);

        // Asynchronous reset mid-frame, then a readback as the first frame.
        @(negedge CLOCK3_SSPCS_o);
        drive(32'h0, 1'b0, 32'h0, 1'b0);
        #3 FPGA_rst = 1'b0;
        #1 chk_all_zero("areset");
        @(posedge CLOCK3_SSPCS_o);
        @(negedge CLOCK3_SSPCS_o);
        FPGA_rst = 1'b1;
        drive(32'h0, 1'b1, 32'ha5a5a5a5, 1'b0);
        @(posedge CLOCK3_SSPCS_o);
        #1;
        chk("rbi.perr", 32'(proto_err), 1);
        chk("rbi.data", rb_data, 32'ha5a5a5a5);
        chk("rbi.tog", 32'(rb_toggle), 1);
        chk("rbi.state", 32'(state), 0);
        chk("rbi.verr", 32'(verify_err), 0);
        chk("rbi.cnt", 32'(frame_cnt), 1);

        // Saturation: count-only frames to address 9.
        @(negedge CLOCK3_SSPCS_o);
        drive(32'h00000009, 1'b0, 32'h0, 1'b0);
        repeat (65533) @(posedge CLOCK3_SSPCS_o);
        #1 chk("sat.fffe", 32'(frame_cnt), 32'hfffe);
        @(posedge CLOCK3_SSPCS_o);
        #1 chk("sat.ffff", 32'(frame_cnt), 32'hffff);
        @(posedge CLOCK3_SSPCS_o);
        #1 chk("sat.hold", 32'(frame_cnt), 32'hffff);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
